// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

  localparam int   ARB_CNT_W = 4;
  localparam logic REQ0      = 1'b0;
  localparam logic REQ1      = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; PRIO breaks ties when both are valid.
module rr_pick2 (
  input  logic [1:0] VALID,
  input  logic       PRIO,
  output logic [1:0] GRANT,
  output logic       WINNER
);
  always_comb begin
    GRANT  = 2'b00;
    WINNER = PRIO;
    case (VALID)
      2'b01:   begin GRANT = 2'b01; WINNER = 1'b0; end
      2'b10:   begin GRANT = 2'b10; WINNER = 1'b1; end
      2'b11:   GRANT = PRIO ? 2'b10 : 2'b01;
      default: ;
    endcase
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load writeback, with a
// round-robin pick, bounded lock bursts and out-of-range address dropping.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic              REQ0_LOCK,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic              REQ1_LOCK,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WR_SRC,
  output logic              ERR
);
  localparam int                   AW1      = ADDR_W + 1;
  localparam logic [AW1-1:0]       ADDR_LIM = AW1'(NUM_REGS);
  localparam logic [ARB_CNT_W-1:0] CNT_MAX  = ARB_CNT_W'(MAX_BURST);

  logic [1:0]             w_valid, w_lock, w_grant_rr, w_ready;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][DATA_W-1:0] w_data;
  logic                   w_winner, w_owner, w_burst_done;
  logic                   w_acc, w_src, w_in_range;

  arb_state_t             r_state, w_state_nx;
  logic                   r_prio, w_prio_nx;
  logic [ARB_CNT_W-1:0]   r_cnt, w_cnt_nx;

  logic                   r_we, r_src, r_err;
  logic [ADDR_W-1:0]      r_a3;
  logic [DATA_W-1:0]      r_wd3;

  assign w_valid = {REQ1_VALID, REQ0_VALID};
  assign w_lock  = {REQ1_LOCK, REQ0_LOCK};
  assign w_addr  = {REQ1_ADDR, REQ0_ADDR};
  assign w_data  = {REQ1_DATA, REQ0_DATA};

  rr_pick2 u_pick (
    .VALID  (w_valid),
    .PRIO   (r_prio),
    .GRANT  (w_grant_rr),
    .WINNER (w_winner)
  );

  assign w_owner      = (r_state == ARB_OWN1) ? REQ1 : REQ0;
  assign w_burst_done = (r_cnt == CNT_MAX);

  // A full burst parks for one cycle with no grant before handing back.
  always_comb begin
    w_ready    = 2'b00;
    w_state_nx = r_state;
    w_prio_nx  = r_prio;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        w_ready = w_grant_rr;
        if (|w_grant_rr) begin
          w_prio_nx = ~w_winner;
          if (w_lock[w_winner]) begin
            w_state_nx = w_winner ? ARB_OWN1 : ARB_OWN0;
            w_cnt_nx   = ARB_CNT_W'(1);
          end
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        w_ready[w_owner] = w_valid[w_owner] & ~w_burst_done;
        if (w_ready[w_owner]) w_cnt_nx = r_cnt + ARB_CNT_W'(1);
        if (w_burst_done || !w_lock[w_owner]) begin
          w_state_nx = ARB_IDLE;
          w_prio_nx  = ~w_owner;
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = ARB_IDLE;
    endcase
    if (RESET) w_ready = 2'b00;
  end

  assign REQ0_READY = w_ready[0];
  assign REQ1_READY = w_ready[1];

  assign w_acc      = |(w_ready & w_valid);
  assign w_src      = w_ready[1] ? REQ1 : REQ0;
  assign w_in_range = {1'b0, w_addr[w_src]} < ADDR_LIM;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ARB_IDLE;
      r_prio  <= REQ0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_prio  <= w_prio_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Dropped beats leave A3/WD3/WR_SRC holding the last real write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
      r_src <= REQ0;
      r_err <= 1'b0;
    end else begin
      r_we <= w_acc & w_in_range;
      if (w_acc) begin
        if (w_in_range) begin
          r_a3  <= w_addr[w_src];
          r_wd3 <= w_data[w_src];
          r_src <= w_src;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign WE3    = r_we;
  assign A3     = r_a3;
  assign WD3    = r_wd3;
  assign WR_SRC = r_src;
  assign ERR    = r_err;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: REQ0 (ALU writeback) and REQ1 (memory-load writeback).
- Arbitration: round-robin, with an optional bounded burst lock.
- Outputs: WE3/A3/WD3 are registered and drive the register file directly.
- Address filtering: out-of-range addresses are dropped and flagged, because the register file decodes only A3[2:0] and would otherwise alias them.

Parameters:
NUM_REGS, 8, number of implemented registers; legal write addresses are 0..NUM_REGS-1.
ADDR_W, 5, register address width.
DATA_W, 32, write data width.
MAX_BURST, 4, maximum accepted beats per locked ownership (1..15).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RESET  in  1  asynchronous, active-high reset.
REQ0_VALID  in  1  requester 0 has a write pending.
REQ0_LOCK  in  1  requester 0 asks to keep the port for consecutive beats.
REQ0_ADDR  in  ADDR_W  requester 0 destination register.
REQ0_DATA  in  DATA_W  requester 0 write data.
REQ0_READY  out  1  requester 0 beat accepted this cycle.
REQ1_VALID, REQ1_LOCK, REQ1_ADDR, REQ1_DATA, REQ1_READY  same as REQ0_* for requester 1.
WE3  out  1  register file write enable (registered).
A3  out  ADDR_W  register file write address (registered).
WD3  out  DATA_W  register file write data (registered).
WR_SRC  out  1  source of the current WE3 beat (0 = REQ0, 1 = REQ1).
ERR  out  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- Reset (asynchronous, immediate):
  - WE3=0, A3=0, WD3=0, WR_SRC=0, ERR=0.
  - State ARB_IDLE, PRIO=0 (REQ0 favoured), burst count=0.
  - REQ0_READY and REQ1_READY forced to 0 while RESET is high.
- Reset mid-burst: ownership is abandoned and the pending output beat is discarded; there is no write after reset deasserts.
- Acceptance: beat n is accepted when REQn_VALID & REQn_READY. READY is combinational from state, PRIO and the VALIDs; at most one READY is high per cycle.
- State ARB_IDLE:
  - Only one VALID high: that requester gets READY=1.
  - Both VALID high: the requester indexed by PRIO gets READY.
  - After an accepted beat, PRIO becomes the other requester.
  - Winner's LOCK=1 with VALID=1: go to ARB_OWNn; the accepted beat counts as burst count=1.
- State ARB_OWNn:
  - Only requester n can get READY; READYn = REQn_VALID.
  - Each accepted beat increments the count.
  - Idle cycles inside ownership (VALID=0, LOCK=1) keep ownership and do not increment the count.
- Leaving ARB_OWNn (return to ARB_IDLE, PRIO = other requester, count=0) when either:
  - REQn_LOCK=0 is sampled, or
  - the count reaches MAX_BURST after an accepted beat.
  - On the cycle of leaving, the other requester is not granted; arbitration resumes the next cycle.
- Output stage, 1-cycle latency:
  - Edge after an accepted beat with ADDR < NUM_REGS: WE3=1, A3=ADDR, WD3=DATA, WR_SRC=n.
  - Edge after an accepted beat with ADDR >= NUM_REGS: WE3=0, ERR=1. ERR stays set until RESET; the beat still counts as accepted and toward the burst.
  - No acceptance: WE3=0; A3, WD3 and WR_SRC hold their values.
- Back-to-back: one write per cycle is sustained. The register file always accepts, so there is no output backpressure.
- Requester data must stay stable while VALID=1 and READY=0; the arbiter does not buffer.

Decomposition:
- Package regfile_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_OWN0, ARB_OWN1};
  - ARB_CNT_W = 4;
  - localparams REQ0 = 1'b0 and REQ1 = 1'b1.
- Sub-module rr_pick2: combinational two-way round-robin pick. Inputs: VALID[1:0] and PRIO. Outputs: GRANT[1:0] (one-hot or zero) and winner index.

Test Plan:
- REQ0 writes addr 3, data 0xDEADBEEF, alone → REQ0_READY=1 that cycle. Next cycle WE3=1, A3=3, WD3=0xDEADBEEF, WR_SRC=0. Following cycle WE3=0.
- Both VALID for 4 cycles (REQ0 addr 1 / 0x11, REQ1 addr 2 / 0x22), no LOCK → WR_SRC sequence 0,1,0,1; WE3 high on 4 consecutive cycles.
- REQ1 LOCK=1 with 6 valid beats while REQ0 is valid, MAX_BURST=4:
  - REQ1 gets 4 beats and REQ0_READY stays 0 throughout;
  - one cycle with no grant;
  - then REQ0 is granted before REQ1's 5th beat.
- REQ0 writes addr 9, data 0x55 → READY=1, WE3 stays 0, ERR=1 the next cycle and stays 1. A following addr 4 write is performed normally.
- RESET asserted in the middle of a REQ0 locked burst, between acceptance and the output edge → WE3=0 immediately, no write issued, ERR=0, and the first grant after release goes to REQ0 when both are valid.
